// File: rtl/lut_pkg.sv
// Shared types and helpers for the programmable lookup-table engine.
package lut_pkg;

  typedef enum logic {
    CLEAR,
    RUN
  } lut_state_e;

  // Number of table entries for a given address width.
  function automatic int unsigned lut_depth(input int unsigned addr_w);
    return 32'd1 << addr_w;
  endfunction

endpackage

// File: rtl/lut_mem.sv
// Table storage: 2^ADDR_W entries of DATA_W bits.
// One synchronous write port and one combinational read port.
// A read at the address being written returns the old entry.
module lut_mem
  import lut_pkg::*;
#(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 1
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);

  localparam int DEPTH = lut_depth(ADDR_W);

  logic [DATA_W-1:0] mem [DEPTH];

  // Storage update; entries carry no reset, the clear sweep zeroes them.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/prog_lut_engine.sv
// Runtime-programmable lookup table with valid/ready lookups, a config
// write port and a one-entry-per-cycle clear sweep after reset/on request.
module prog_lut_engine
  import lut_pkg::*;
#(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cfg_we,
  input  logic [ADDR_W-1:0] cfg_addr,
  input  logic [DATA_W-1:0] cfg_data,
  input  logic              clr_req,
  output logic              busy,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [ADDR_W-1:0] in_addr,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [ADDR_W-1:0] out_addr
);

  localparam logic [ADDR_W-1:0] CNT_LAST = '1;

  lut_state_e        state, state_nx;
  logic [ADDR_W-1:0] clr_cnt, clr_cnt_nx;

  logic              mem_we;
  logic [ADDR_W-1:0] mem_waddr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] rd_data_p0;

  logic              vld_p1;
  logic [DATA_W-1:0] data_p1;
  logic [ADDR_W-1:0] addr_p1;
  logic              accept;

  lut_mem #(
    .ADDR_W(ADDR_W),
    .DATA_W(DATA_W)
  ) u_mem (
    .clk  (clk),
    .we   (mem_we),
    .waddr(mem_waddr),
    .wdata(mem_wdata),
    .raddr(in_addr),
    .rdata(rd_data_p0)
  );

  // FSM state and clear counter registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= CLEAR;
      clr_cnt <= '0;
    end else begin
      state   <= state_nx;
      clr_cnt <= clr_cnt_nx;
    end
  end

  // Next-state logic and write-port mux between clear sweep and config port.
  always_comb begin
    state_nx   = state;
    clr_cnt_nx = clr_cnt;
    busy       = 1'b0;
    mem_we     = 1'b0;
    mem_waddr  = cfg_addr;
    mem_wdata  = cfg_data;
    unique case (state)
      CLEAR: begin
        busy      = 1'b1;
        mem_we    = 1'b1;
        mem_waddr = clr_cnt;
        mem_wdata = '0;
        if (clr_req) begin
          clr_cnt_nx = '0;
        end else if (clr_cnt == CNT_LAST) begin
          clr_cnt_nx = '0;
          state_nx   = RUN;
        end else begin
          clr_cnt_nx = clr_cnt + 1'b1;
        end
      end
      RUN: begin
        mem_we = cfg_we;
        if (clr_req) begin
          clr_cnt_nx = '0;
          state_nx   = CLEAR;
        end
      end
      default: state_nx = CLEAR;
    endcase
  end

  assign in_ready = (state == RUN) && (!vld_p1 || out_ready);
  assign accept   = in_valid && in_ready;

  // ---- stage p0 -> p1: table read captured into the output register ----
  // Output register; holds its contents while stalled.
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_p1  <= 1'b0;
      data_p1 <= '0;
      addr_p1 <= '0;
    end else if (accept) begin
      vld_p1  <= 1'b1;
      data_p1 <= rd_data_p0;
      addr_p1 <= in_addr;
    end else if (out_ready) begin
      vld_p1  <= 1'b0;
    end
  end

  assign out_valid = vld_p1;
  assign out_data  = data_p1;
  assign out_addr  = addr_p1;

endmodule

// File: tb/tb_prog_lut_engine.sv
// Directed bench for prog_lut_engine: a default 4x1 instance and an 8x8 instance.
module tb_prog_lut_engine;

  logic clk = 1'b0;
  logic rst;

  // Default instance (ADDR_W=4, DATA_W=1)
  logic       cfg_we, clr_req, busy, in_valid, in_ready, out_valid, out_ready;
  logic [3:0] cfg_addr, in_addr, out_addr;
  logic [0:0] cfg_data, out_data;

  // Wide instance (ADDR_W=3, DATA_W=8)
  logic       b_cfg_we, b_clr_req, b_busy, b_in_valid, b_in_ready, b_out_valid, b_out_ready;
  logic [2:0] b_cfg_addr, b_in_addr, b_out_addr;
  logic [7:0] b_cfg_data, b_out_data;

  int tests = 0;
  int fails = 0;

  typedef struct {
    logic [3:0] addr;
    logic [0:0] data;
  } vec_t;
  vec_t vt[16];

  always #5 clk = ~clk;

  prog_lut_engine #(.ADDR_W(4), .DATA_W(1)) dut (
    .clk(clk), .rst(rst), .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_data(cfg_data),
    .clr_req(clr_req), .busy(busy), .in_valid(in_valid), .in_ready(in_ready),
    .in_addr(in_addr), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_addr(out_addr)
  );

  prog_lut_engine #(.ADDR_W(3), .DATA_W(8)) dut_w (
    .clk(clk), .rst(rst), .cfg_we(b_cfg_we), .cfg_addr(b_cfg_addr), .cfg_data(b_cfg_data),
    .clr_req(b_clr_req), .busy(b_busy), .in_valid(b_in_valid), .in_ready(b_in_ready),
    .in_addr(b_in_addr), .out_valid(b_out_valid), .out_ready(b_out_ready),
    .out_data(b_out_data), .out_addr(b_out_addr)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic cfg_write(input logic [3:0] a, input logic [0:0] d);
    cfg_we = 1'b1; cfg_addr = a; cfg_data = d;
    step();
    cfg_we = 1'b0;
  endtask

  // Stream vt[0..n-1] back to back and check each result one cycle later.
  task automatic run_vecs(input int n);
    out_ready = 1'b1;
    for (int i = 0; i < n; i++) begin
      in_valid = 1'b1;
      in_addr  = vt[i].addr;
      chk("stream_in_ready", 32'(in_ready), 32'd1);
      step();
      chk("stream_out_valid", 32'(out_valid), 32'd1);
      chk("stream_out_addr", 32'(out_addr), 32'(vt[i].addr));
      chk("stream_out_data", 32'(out_data), 32'(vt[i].data));
    end
    in_valid = 1'b0;
    step();
    chk("stream_drain_valid", 32'(out_valid), 32'd0);
  endtask

  task automatic fill_table(input logic [15:0] mask);
    for (int i = 0; i < 16; i++) begin
      vt[i].addr = 4'(i);
      vt[i].data = mask[i];
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int bad;
    logic [15:0] prog_mask;

    rst = 1'b1;
    cfg_we = 0; cfg_addr = 0; cfg_data = 0; clr_req = 0;
    in_valid = 0; in_addr = 0; out_ready = 1;
    b_cfg_we = 0; b_cfg_addr = 0; b_cfg_data = 0; b_clr_req = 0;
    b_in_valid = 0; b_in_addr = 0; b_out_ready = 1;

    // ---- reset state and power-on sweep ----
    step();
    rst = 1'b0;
    chk("rst_busy", 32'(busy), 32'd1);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_data", 32'(out_data), 32'd0);
    chk("rst_out_addr", 32'(out_addr), 32'd0);
    n = 0; bad = 0;
    while (busy && n < 100) begin
      if (in_ready) bad++;
      n++;
      step();
    end
    chk("sweep_len", 32'(n), 32'd16);
    chk("sweep_in_ready_low", 32'(bad), 32'd0);
    chk("run_in_ready", 32'(in_ready), 32'd1);

    fill_table(16'h0000);
    run_vecs(16);

    // ---- program truth table and stream all inputs ----
    prog_mask = 16'hFF4C;
    for (int i = 0; i < 16; i++) cfg_write(4'(i), prog_mask[i]);
    fill_table(prog_mask);
    run_vecs(16);

    // ---- backpressure ----
    in_valid = 1'b1; in_addr = 4'd6; out_ready = 1'b0;
    step();
    in_addr = 4'd3;
    for (int i = 0; i < 5; i++) begin
      chk("stall_valid", 32'(out_valid), 32'd1);
      chk("stall_data", 32'(out_data), 32'd1);
      chk("stall_addr", 32'(out_addr), 32'd6);
      chk("stall_in_ready", 32'(in_ready), 32'd0);
      step();
    end
    out_ready = 1'b1;
    #1;
    chk("release_in_ready", 32'(in_ready), 32'd1);
    step();
    chk("release_next_addr", 32'(out_addr), 32'd3);
    chk("release_next_data", 32'(out_data), 32'd1);
    chk("release_next_valid", 32'(out_valid), 32'd1);
    in_valid = 1'b0;
    step();
    chk("valid_drop", 32'(out_valid), 32'd0);

    // ---- same-cycle write and lookup at address 5 ----
    cfg_we = 1'b1; cfg_addr = 4'd5; cfg_data = 1'b1;
    in_valid = 1'b1; in_addr = 4'd5;
    step();
    cfg_we = 1'b0;
    chk("collide_old", 32'(out_data), 32'd0);
    chk("collide_addr", 32'(out_addr), 32'd5);
    step();
    chk("collide_new", 32'(out_data), 32'd1);
    in_valid = 1'b0;
    step();

    // ---- consecutive writes: last wins ----
    cfg_write(4'd7, 1'b1);
    cfg_write(4'd7, 1'b0);
    in_valid = 1'b1; in_addr = 4'd7;
    step();
    in_valid = 1'b0;
    chk("last_write_wins", 32'(out_data), 32'd0);
    step();

    // ---- clear with a pending result and config writes during the sweep ----
    in_valid = 1'b1; in_addr = 4'd6; out_ready = 1'b0;
    step();
    in_valid = 1'b0; clr_req = 1'b1;
    step();
    clr_req = 1'b0;
    cfg_we = 1'b1; cfg_addr = 4'd0; cfg_data = 1'b1;
    n = 0; bad = 0;
    while (busy && n < 100) begin
      if (in_ready) bad++;
      if (n == 2) begin
        chk("clr_pending_valid", 32'(out_valid), 32'd1);
        chk("clr_pending_data", 32'(out_data), 32'd1);
        chk("clr_pending_addr", 32'(out_addr), 32'd6);
        out_ready = 1'b1;
      end
      if (n == 3) chk("clr_pending_done", 32'(out_valid), 32'd0);
      n++;
      step();
    end
    cfg_we = 1'b0;
    chk("clr_sweep_len", 32'(n), 32'd16);
    chk("clr_in_ready_low", 32'(bad), 32'd0);
    fill_table(16'h0000);
    run_vecs(16);

    // ---- wide instance: config readback, re-triggered sweep ----
    b_cfg_we = 1'b1; b_cfg_addr = 3'd7; b_cfg_data = 8'hA5;
    step();
    b_cfg_we = 1'b0;
    b_in_valid = 1'b1; b_in_addr = 3'd7;
    step();
    b_in_valid = 1'b0;
    chk("wide_readback", 32'(b_out_data), 32'hA5);
    chk("wide_addr", 32'(b_out_addr), 32'd7);
    b_clr_req = 1'b1;
    step();
    b_clr_req = 1'b0;
    n = 0;
    while (b_busy && n < 100) begin
      n++;
      b_clr_req = (n == 4);
      step();
    end
    b_clr_req = 1'b0;
    chk("wide_retrigger_len", 32'(n), 32'd12);
    b_in_valid = 1'b1; b_in_addr = 3'd7;
    step();
    b_in_valid = 1'b0;
    chk("wide_cleared", 32'(b_out_data), 32'h00);
    step();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/prog_lut_engine.md
Name: prog_lut_engine

Overview:
Runtime-programmable lookup table. Holds 2^ADDR_W entries of DATA_W bits, each a truth-table output for one ADDR_W-bit input vector. Software or an upstream controller loads entries through a config write port. Datapath lookups flow through a valid/ready interface with a registered, stall-safe output. A built-in clear sequencer zeroes the table after reset or on request, one entry per cycle.

Parameters:
ADDR_W, 4, lookup input width; table depth = 2^ADDR_W
DATA_W, 1, bits per table entry / lookup result width

Ports:
clk  in  1  clock, all logic on rising edge
rst  in  1  synchronous active-high reset
cfg_we  in  1  config write strobe, honoured only when busy=0
cfg_addr  in  ADDR_W  config write address
cfg_data  in  DATA_W  config write data
clr_req  in  1  single-cycle pulse; start table clear sweep
busy  out  1  high while clear sweep in progress
in_valid  in  1  lookup request valid
in_ready  out  1  lookup request accepted when in_valid&in_ready
in_addr  in  ADDR_W  lookup input vector
out_valid  out  1  lookup result valid
out_ready  in  1  downstream accepts result
out_data  out  DATA_W  table[in_addr] at acceptance
out_addr  out  ADDR_W  echo of the accepted in_addr

Behaviour:
- Reset (rst=1 at clk edge): state=CLEAR, clr_cnt=0, out_valid=0, out_data=0, out_addr=0, busy=1. Table contents are not reset directly; the sweep zeroes them.
- FSM states:
  - CLEAR: each cycle writes table[clr_cnt]=0 and increments clr_cnt. At clr_cnt == 2^ADDR_W-1 the last write occurs and the next state is RUN. The sweep lasts exactly 2^ADDR_W cycles. busy=1 throughout.
  - RUN: busy=0. Lookups and config writes are serviced.
  - RUN -> CLEAR on clr_req=1. clr_cnt restarts at 0.
- clr_req during CLEAR restarts the sweep from 0, so the full 2^ADDR_W cycles run again.
- in_ready = (state==RUN) && (!out_valid || out_ready). Combinational from state and out_* only; no dependence on in_valid.
- Lookup latency is 1 cycle. On acceptance, out_data<=table[in_addr], out_addr<=in_addr, out_valid<=1.
- out_valid drops to 0 on the cycle after a handshake (out_valid&out_ready) with no new acceptance.
- Back-to-back: with out_ready held at 1, one result per cycle, no bubbles.
- Stall: while out_valid=1 and out_ready=0, out_data and out_addr hold stable and in_ready=0.
- cfg_we while busy=1 is ignored, with no side effect.
- Same-cycle cfg_we and lookup at the same address: the lookup returns the OLD entry; the new value is visible to lookups accepted from the next cycle.
- Consecutive cfg writes to the same address: last write wins.
- clr_req while out_valid=1: the pending result is held until the handshake completes and is not discarded. New acceptances are blocked until RUN is re-entered.
- Mid-sweep rst: identical to power-on reset, so the sweep restarts at 0.
- The clr_cnt counter is ADDR_W bits wide. End-of-sweep is detected on the all-ones value, not on overflow.
- All entries read 0 after any completed sweep.

Decomposition:
- Package lut_pkg holds:
  - typedef enum logic {CLEAR, RUN} lut_state_e
  - a localparam function for depth (1<<ADDR_W)
- Sub-module lut_mem is the natural split: 2^ADDR_W x DATA_W storage with one write port and one combinational read port.
  - The top muxes the write port between the clear sequencer (during CLEAR) and cfg_* (during RUN).
  - The top owns the FSM, clear counter and output register.

Test Plan:
- Reset then idle: assert rst 1 cycle; busy=1 for exactly 16 cycles (ADDR_W=4), in_ready=0 throughout; then lookups of addr 0..15 all return 0.
- Program function: after clear, write 1 to addrs {2,3,6,8,9,10,11,12,13,14,15} and 0 elsewhere; stream lookups 0..15 with out_ready=1. Expect out_data=0,0,1,1,0,0,1,0,1,1,1,1,1,1,1,1 at 1-cycle latency, out_addr echoed, no bubbles.
- Backpressure: accept addr 6, hold out_ready=0 for 5 cycles. out_valid=1, out_data=1, out_addr=6 stay stable and in_ready=0; release out_ready and the next lookup is accepted that cycle.
- Write/read collision: table[5]=0, same cycle cfg_we addr5 data1 and lookup addr5. Result is 0; the next lookup of 5 returns 1.
- Clear during operation: table programmed, pending result with out_ready=0, pulse clr_req. Pending result survives the handshake, busy=1 for 16 cycles, cfg_we during the sweep is ignored, all entries read 0 afterwards.
- Re-trigger and wide config (DATA_W=8, ADDR_W=3): pulse clr_req at sweep cycle 4, expect busy for 4+8 cycles total. Write 8'hA5 to addr 7 and read back 8'hA5.
